// File: rtl/btn_debounce_if.sv
// Signal bundle between the board button pins and btn_debounce.
// The btn_tgl member exists only when BTN_TOGGLE_EN is defined.
interface btn_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
`ifdef BTN_TOGGLE_EN
  logic [N_BTN-1:0] btn_tgl;
`endif

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_rise,
    input  btn_fall
`ifdef BTN_TOGGLE_EN
    , input btn_tgl
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_rise,
    output btn_fall
`ifdef BTN_TOGGLE_EN
    , output btn_tgl
`endif
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel 2-flop synchroniser and counter debouncer with press/release strobes.
// Optional BTN_TOGGLE_EN adds a per-channel toggle register flipped by each accepted press.
module btn_debounce #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  btn_debounce_if.slave     bus
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] db_q;
  logic [N_BTN-1:0] db_d;
  logic [N_BTN-1:0] rise_q;
  logic [N_BTN-1:0] rise_d;
  logic [N_BTN-1:0] fall_q;
  logic [N_BTN-1:0] fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             commit_s;

    // A single-cycle debounce window commits straight from STABLE.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      commit_s = 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s2_q[i] != db_q[i]) begin
            if (DB_CYCLES == 1) begin
              commit_s = 1'b1;
              cnt_d    = '0;
            end else begin
              state_d = ST_PENDING;
              cnt_d   = CNT_ONE;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_PENDING: begin
          if (s2_q[i] == db_q[i]) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = ST_STABLE;
            cnt_d    = '0;
            commit_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign db_d[i]   = commit_s ? s2_q[i] : db_q[i];
    assign rise_d[i] = commit_s & s2_q[i];
    assign fall_d[i] = commit_s & ~s2_q[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.btn_db   = db_q;
  assign bus.btn_rise = rise_q;
  assign bus.btn_fall = fall_q;

`ifdef BTN_TOGGLE_EN
  logic [N_BTN-1:0] tgl_q;
  logic [N_BTN-1:0] tgl_d;

  // Flips on the cycle after the registered rise strobe.
  assign tgl_d = tgl_q ^ rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_q <= '0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  assign bus.btn_tgl = tgl_q;
`endif
endmodule
